// File: rtl/elevator_scheduler.sv
// elevator_scheduler: four-floor collective (SCAN) elevator controller.
// Latches hall/car calls, picks the travel direction, times each hop
// between floors and the door-open window, and drives floor/status flags.
// Optional build macro ESTOP_EN adds an `estop` input and a HALT state.
module elevator_scheduler #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset,
`ifdef ESTOP_EN
  input  logic       estop,
`endif
  input  logic [3:0] call_btn,
  output logic [1:0] floor,
  output logic       UES,
  output logic       LES,
  output logic       IS,
  output logic       door_open,
  output logic [3:0] pending
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR_OPEN
`ifdef ESTOP_EN
    , S_HALT
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      floor_q, floor_d, next_floor;
  logic            dir_up_q, dir_up_d;
  logic [3:0]      pending_q, pending_d, pend_n;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            ues_q, les_q, is_q, door_q;

  // True when any call is latched strictly above floor f.
  function automatic logic any_above(input logic [3:0] p, input logic [1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (p[i] && (i > int'(f))) r = 1'b1;
    end
    return r;
  endfunction

  // True when any call is latched strictly below floor f.
  function automatic logic any_below(input logic [3:0] p, input logic [1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (p[i] && (i < int'(f))) r = 1'b1;
    end
    return r;
  endfunction

  // Next-state decision: direction choice, hop timing, door timing, call latching.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    pend_n     = pending_q | call_btn;
    state_d    = state_q;
    floor_d    = floor_q;
    dir_up_d   = dir_up_q;
    pending_d  = pend_n;
    tcnt_d     = tcnt_q;
    dcnt_d     = dcnt_q;
    next_floor = floor_q;

    unique case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        dcnt_d = '0;
        if (pend_n[floor_q]) begin
          state_d            = S_DOOR_OPEN;
          pending_d[floor_q] = 1'b0;
        end else if (any_above(pend_n, floor_q) && any_below(pend_n, floor_q)) begin
          state_d = dir_up_q ? S_MOVE_UP : S_MOVE_DOWN;
        end else if (any_above(pend_n, floor_q)) begin
          state_d  = S_MOVE_UP;
          dir_up_d = 1'b1;
        end else if (any_below(pend_n, floor_q)) begin
          state_d  = S_MOVE_DOWN;
          dir_up_d = 1'b0;
        end
      end

      S_MOVE_UP, S_MOVE_DOWN: begin
        if (tcnt_q == T_LAST) begin
          // Arrival is judged against the floor the car is just reaching.
          next_floor = (state_q == S_MOVE_UP) ? floor_q + 2'd1 : floor_q - 2'd1;
          floor_d    = next_floor;
          tcnt_d     = '0;
          if (pend_n[next_floor]) begin
            state_d               = S_DOOR_OPEN;
            dcnt_d                = '0;
            pending_d[next_floor] = 1'b0;
          end else if ((state_q == S_MOVE_UP) ? !any_above(pend_n, next_floor)
                                              : !any_below(pend_n, next_floor)) begin
            state_d = S_IDLE;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      S_DOOR_OPEN: begin
        pending_d[floor_q] = 1'b0;
        if (call_btn[floor_q]) begin
          dcnt_d = '0;  // hold-open: a fresh call here restarts the window
        end else if (dcnt_q == D_LAST) begin
          state_d = S_IDLE;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

`ifdef ESTOP_EN
      S_HALT: begin
        state_d   = S_IDLE;
        pending_d = '0;
        tcnt_d    = '0;
        dcnt_d    = '0;
      end
`endif

      default: state_d = S_IDLE;
    endcase

`ifdef ESTOP_EN
    // Emergency stop overrides every decision; the floor is simply held.
    if (estop) begin
      state_d   = S_HALT;
      floor_d   = floor_q;
      dir_up_d  = dir_up_q;
      pending_d = '0;
      tcnt_d    = '0;
      dcnt_d    = '0;
    end
`endif
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge.
    if (reset) begin
      state_q   <= S_IDLE;
      floor_q   <= 2'd0;
      dir_up_q  <= 1'b1;
      pending_q <= 4'd0;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
      ues_q     <= 1'b0;
      les_q     <= 1'b0;
      is_q      <= 1'b1;
      door_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_up_q  <= dir_up_d;
      pending_q <= pending_d;
      tcnt_q    <= tcnt_d;
      dcnt_q    <= dcnt_d;
      ues_q     <= (state_d == S_MOVE_UP);
      les_q     <= (state_d == S_MOVE_DOWN);
      is_q      <= (state_d == S_IDLE);
      door_q    <= (state_d == S_DOOR_OPEN);
    end
  end

  assign floor     = floor_q;
  assign pending   = pending_q;
  assign UES       = ues_q;
  assign LES       = les_q;
  assign IS        = is_q;
  assign door_open = door_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler: directed scenarios with
// hand-computed expectations, then randomized calls/resets, all compared
// every cycle against a behavioural model of the elevator.
module tb_elevator_scheduler;

  localparam int T = 8;
  localparam int D = 4;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;
  localparam int M_HALT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       estop;
  logic [3:0] call_btn;
  logic [1:0] floor;
  logic       ues, les, is_w, door_open;
  logic [3:0] pending;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: car position, mode, latched calls, cycles left.
  int         m_mode  = M_IDLE;
  int         m_floor = 0;
  bit         m_up    = 1'b1;
  logic [3:0] m_pend  = 4'd0;
  int         m_hop   = 0;
  int         m_door  = 0;

  always #5 clk = ~clk;

  elevator_scheduler #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef ESTOP_EN
    .estop     (estop),
`endif
    .call_btn  (call_btn),
    .floor     (floor),
    .UES       (ues),
    .LES       (les),
    .IS        (is_w),
    .door_open (door_open),
    .pending   (pending)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the elevator, described from the service rules.
  task automatic model_step(input logic [3:0] btn, input logic rst, input logic stop);
    logic [3:0] p;
    int n_above, n_below;
    bit ahead;
    if (rst) begin
      m_mode = M_IDLE; m_floor = 0; m_up = 1'b1; m_pend = 4'd0; m_hop = 0; m_door = 0;
      return;
    end
    if (stop) begin
      m_mode = M_HALT; m_pend = 4'd0; m_hop = 0; m_door = 0;
      return;
    end
    p = m_pend | btn;
    n_above = 0;
    n_below = 0;
    for (int i = 0; i < 4; i++) begin
      if (p[i] && i > m_floor) n_above++;
      if (p[i] && i < m_floor) n_below++;
    end
    case (m_mode)
      M_IDLE: begin
        if (p[m_floor]) begin
          m_mode = M_DOOR; m_door = D; p[m_floor] = 1'b0;
        end else if (n_above > 0 && (n_below == 0 || m_up)) begin
          m_mode = M_UP; m_up = 1'b1; m_hop = T;
        end else if (n_below > 0) begin
          m_mode = M_DOWN; m_up = 1'b0; m_hop = T;
        end
      end
      M_UP, M_DOWN: begin
        m_hop--;
        if (m_hop == 0) begin
          m_floor = (m_mode == M_UP) ? m_floor + 1 : m_floor - 1;
          ahead = 1'b0;
          for (int i = 0; i < 4; i++) begin
            if (p[i] && ((m_mode == M_UP) ? (i > m_floor) : (i < m_floor))) ahead = 1'b1;
          end
          if (p[m_floor]) begin
            m_mode = M_DOOR; m_door = D; p[m_floor] = 1'b0;
          end else if (ahead) begin
            m_hop = T;
          end else begin
            m_mode = M_IDLE;
          end
        end
      end
      M_DOOR: begin
        p[m_floor] = 1'b0;
        if (btn[m_floor]) m_door = D;
        else begin
          m_door--;
          if (m_door == 0) m_mode = M_IDLE;
        end
      end
      default: begin
        m_mode = M_IDLE; p = 4'd0;
      end
    endcase
    m_pend = p;
  endtask

  // Advance the model with exactly the inputs the DUT samples at this edge.
  always @(posedge clk) model_step(call_btn, reset, estop);

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_floor", int'(floor), m_floor);
      check("cyc_UES", int'(ues), int'(m_mode == M_UP));
      check("cyc_LES", int'(les), int'(m_mode == M_DOWN));
      check("cyc_IS", int'(is_w), int'(m_mode == M_IDLE));
      check("cyc_door", int'(door_open), int'(m_mode == M_DOOR));
      check("cyc_pending", int'(pending), int'(m_pend));
    end
  end

  task automatic pulse(input logic [3:0] b);
    call_btn = b;
    @(negedge clk);
    call_btn = 4'd0;
  endtask

  task automatic wait_door(input int f, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (door_open && int'(floor) == f) hit = 1'b1;
      else @(negedge clk);
    end
    check("wait_door", int'(hit), 1);
  endtask

  task automatic wait_floor(input int f, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (int'(floor) == f) hit = 1'b1;
      else @(negedge clk);
    end
    check("wait_floor", int'(hit), 1);
  endtask

  task automatic wait_idle(input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (is_w) hit = 1'b1;
      else @(negedge clk);
    end
    check("wait_idle", int'(hit), 1);
  endtask

  task automatic goto_floor(input int f);
    pulse(4'(1 << f));
    wait_door(f, 100);
    wait_idle(100);
  endtask

  initial begin
    reset    = 1'b1;
    estop    = 1'b0;
    call_btn = 4'd0;

    // Reset held for two edges.
    repeat (2) @(negedge clk);
    check("rst_floor", int'(floor), 0);
    check("rst_IS", int'(is_w), 1);
    check("rst_flags", int'({ues, les, door_open}), 0);
    check("rst_pending", int'(pending), 0);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Call at the current floor: door opens next cycle for D cycles.
    pulse(4'b0001);
    check("t2_door", int'(door_open), 1);
    check("t2_pending", int'(pending), 0);
    check("t2_model_door", int'(m_mode == M_DOOR), 1);
    repeat (3) @(negedge clk);
    check("t2_door_last", int'(door_open), 1);
    @(negedge clk);
    check("t2_idle", int'(is_w), 1);

    // Two floors up: UES next cycle, one floor per T cycles, door at 2T+1.
    pulse(4'b0100);
    check("t3_UES", int'(ues), 1);
    check("t3_pending", int'(pending), 4'b0100);
    repeat (8) @(negedge clk);
    check("t3_floor1", int'(floor), 1);
    check("t3_model_floor1", m_floor, 1);
    repeat (8) @(negedge clk);
    check("t3_floor2", int'(floor), 2);
    check("t3_door", int'(door_open), 1);
    check("t3_pending_clr", int'(pending), 0);
    wait_idle(50);

    // Park at floor 1 heading up, then call both ends at once.
    goto_floor(0);
    goto_floor(1);
    pulse(4'b1001);
    check("t5_UES_first", int'(ues), 1);
    check("t5_pending", int'(pending), 4'b1001);
    wait_door(3, 40);
    check("t5_floor0_waiting", int'(pending[0]), 1);
    @(negedge clk);
    pulse(4'b1000);
    repeat (3) @(negedge clk);
    check("t5_hold_open", int'(door_open), 1);
    @(negedge clk);
    check("t5_idle_after_door", int'(is_w), 1);
    wait_door(0, 60);
    wait_idle(50);

    // Call down while travelling up: upward call finishes first.
    pulse(4'b1000);
    wait_floor(1, 20);
    pulse(4'b0001);
    wait_door(3, 40);
    check("t4_down_call_kept", int'(pending[0]), 1);
    wait_door(0, 80);
    wait_idle(50);

    // Reset mid-travel returns the car to floor 0 at once.
    pulse(4'b1000);
    wait_floor(1, 20);
    check("t6_moving", int'(ues), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_floor", int'(floor), 0);
    check("t6_IS", int'(is_w), 1);
    check("t6_pending", int'(pending), 0);

`ifdef ESTOP_EN
    // Emergency stop mid-travel: all flags low, floor held, calls dropped.
    pulse(4'b1000);
    wait_floor(1, 20);
    estop = 1'b1;
    @(negedge clk);
    check("es_flags", int'({ues, les, is_w, door_open}), 0);
    check("es_floor", int'(floor), 1);
    check("es_pending", int'(pending), 0);
    estop = 1'b0;
    @(negedge clk);
    check("es_idle", int'(is_w), 1);
`endif

    // Randomized calls with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      for (int b = 0; b < 4; b++) call_btn[b] = ($urandom_range(0, 9) == 0);
`ifdef ESTOP_EN
      estop = ($urandom_range(0, 99) < 2);
`endif
      @(negedge clk);
    end
    reset    = 1'b0;
    estop    = 1'b0;
    call_btn = 4'd0;
    @(negedge clk);
    cmp_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
